// File: rtl/disp_mode_ctrl.sv
// rtl/disp_mode_ctrl.sv - multi-source digit display selector with manual/auto scroll and alarm override
module disp_mode_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int NUM_SRC    = 4,
   parameter int AUTO_SEC   = 5,
   parameter int ALARM_SRC  = NUM_SRC - 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enb,
   input  logic [NUM_SRC*NUM_DIGITS*4-1:0] src_data,
   input  logic [NUM_SRC-1:0]              src_valid,
   input  logic                            mode_btn,
   input  logic                            auto_en,
   input  logic                            alarm_req,
   output logic [NUM_DIGITS*4-1:0]         led,
   output logic [2:0]                      cur_src,
   output logic                            alarm_ack
);

   localparam int DW = NUM_DIGITS * 4;

   typedef enum logic [1:0] {MANUAL, AUTO, ALARM} state_t;

   state_t     state, state_n, saved_state, saved_state_n;
   logic [2:0] cur_n, saved_src, saved_src_n, adv_src;
   logic [5:0] tick, tick_n;
   logic       blink_on, blink_n, ack_n;
   logic       sync1, sync2, sync3, alarm_prev;
   logic       press, alarm_rise, alarm_fall, cur_valid, adv;
   logic [3:0] idx;
   logic [7:0] valid8;
   logic [DW-1:0] sel_data;

   assign press      = sync2 & ~sync3;
   assign alarm_rise = alarm_req & ~alarm_prev;
   assign alarm_fall = ~alarm_req & alarm_prev;
   assign valid8     = 8'(src_valid);
   assign cur_valid  = valid8[cur_src];

   // Nearest valid source above cur_src, wrapping; the lowest offset wins
   always_comb begin
      adv_src = cur_src;
      idx     = '0;
      for (int i = NUM_SRC - 1; i >= 1; i--) begin
         idx = {1'b0, cur_src} + 4'(i);
         if (idx >= 4'(NUM_SRC)) idx = idx - 4'(NUM_SRC);
         if (valid8[idx[2:0]]) adv_src = idx[2:0];
      end
   end

   always_comb begin
      sel_data = '1;
      for (int s = 0; s < NUM_SRC; s++)
         if (cur_src == 3'(s)) sel_data = src_data[s*DW +: DW];
   end

   always_comb begin
      state_n       = state;
      cur_n         = cur_src;
      tick_n        = tick;
      blink_n       = blink_on;
      saved_state_n = saved_state;
      saved_src_n   = saved_src;
      ack_n         = 1'b0;
      adv           = 1'b0;
      case (state)
         MANUAL, AUTO: begin
            if (alarm_rise) begin
               saved_state_n = state;
               saved_src_n   = cur_src;
               state_n       = ALARM;
               cur_n         = 3'(ALARM_SRC);
               blink_n       = 1'b1;
            end else begin
               adv = press | ~cur_valid;
               if (state == MANUAL) begin
                  if (auto_en) begin
                     state_n = AUTO;
                     tick_n  = '0;
                  end
               end else if (!auto_en) begin
                  state_n = MANUAL;
               end else if (press) begin
                  tick_n = '0;
               end else if (enb) begin
                  if (tick == 6'(AUTO_SEC - 1)) begin
                     adv    = 1'b1;
                     tick_n = '0;
                  end else begin
                     tick_n = tick + 6'd1;
                  end
               end
               if (adv) cur_n = adv_src;
            end
         end
         ALARM: begin
            if (press) begin
               ack_n   = 1'b1;
               state_n = saved_state;
               cur_n   = saved_src;
            end else if (alarm_fall) begin
               state_n = saved_state;
               cur_n   = saved_src;
            end else if (enb) begin
               blink_n = ~blink_on;
            end
         end
         default: state_n = MANUAL;
      endcase
   end

   // alarm_prev resets high so a level already asserted out of reset is not taken as a rise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= MANUAL;
         saved_state <= MANUAL;
         cur_src     <= '0;
         saved_src   <= '0;
         tick        <= '0;
         blink_on    <= 1'b1;
         alarm_ack   <= 1'b0;
         led         <= '1;
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         sync3       <= 1'b0;
         alarm_prev  <= 1'b1;
      end else begin
         state       <= state_n;
         saved_state <= saved_state_n;
         cur_src     <= cur_n;
         saved_src   <= saved_src_n;
         tick        <= tick_n;
         blink_on    <= blink_n;
         alarm_ack   <= ack_n;
         led         <= (state == ALARM && !blink_on) ? '1 : sel_data;
         sync1       <= mode_btn;
         sync2       <= sync1;
         sync3       <= sync2;
         alarm_prev  <= alarm_req;
      end
   end

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// tb/tb_disp_mode_ctrl.sv - scoreboard bench for disp_mode_ctrl against a behavioural model
module tb_disp_mode_ctrl;

   localparam int ND = 4;
   localparam int NS = 4;
   localparam int AS = 5;
   localparam int AL = NS - 1;
   localparam int DW = ND * 4;

   logic clk = 1'b0;
   logic rst, enb, mode_btn, auto_en, alarm_req;
   logic [NS-1:0]    src_valid;
   logic [NS*DW-1:0] src_data;
   logic [DW-1:0]    led;
   logic [2:0]       cur_src;
   logic             alarm_ack;

   logic n_rst, n_enb, n_btn, n_auto, n_alarm;
   logic [NS-1:0]    n_valid;
   logic [NS*DW-1:0] n_data;

   typedef struct {
      logic [2:0]    cur;
      logic [DW-1:0] led;
      logic          ack;
   } exp_t;
   exp_t q[$];

   int vectors = 0;
   int miscompares = 0;

   // Model: mode flags rather than a state code; button history in pin-sample order
   int m_cur, m_saved_cur, m_tick;
   bit m_alarm, m_auto, m_saved_auto, m_blink, m_aprev;
   bit bh[3];

   disp_mode_ctrl #(.NUM_DIGITS(ND), .NUM_SRC(NS), .AUTO_SEC(AS), .ALARM_SRC(AL)) dut (
      .clk(clk), .rst(rst), .enb(enb), .src_data(src_data), .src_valid(src_valid),
      .mode_btn(mode_btn), .auto_en(auto_en), .alarm_req(alarm_req),
      .led(led), .cur_src(cur_src), .alarm_ack(alarm_ack)
   );

   always #5 clk = ~clk;

   function automatic int next_valid(int cur, logic [NS-1:0] v);
      for (int k = 1; k < NS; k++)
         if (v[(cur + k) % NS]) return (cur + k) % NS;
      return cur;
   endfunction

   task automatic reset_model();
      m_cur = 0; m_saved_cur = 0; m_tick = 0;
      m_alarm = 0; m_auto = 0; m_saved_auto = 0; m_blink = 1; m_aprev = 1;
      bh[0] = 0; bh[1] = 0; bh[2] = 0;
   endtask

   task automatic model_step();
      exp_t e;
      bit press, rise, fall, adv;
      if (n_rst) begin
         reset_model();
         e.cur = 3'd0; e.led = '1; e.ack = 1'b0;
         q.push_back(e);
         return;
      end
      e.led = (m_alarm && !m_blink) ? {DW{1'b1}} : n_data[m_cur*DW +: DW];
      e.ack = 1'b0;
      press = bh[1] && !bh[2];
      bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = n_btn;
      rise = n_alarm && !m_aprev;
      fall = !n_alarm && m_aprev;
      m_aprev = n_alarm;
      if (!m_alarm) begin
         if (rise) begin
            m_saved_cur = m_cur; m_saved_auto = m_auto;
            m_alarm = 1; m_cur = AL; m_blink = 1;
         end else begin
            adv = press || !n_valid[m_cur];
            if (!m_auto) begin
               if (n_auto) begin m_auto = 1; m_tick = 0; end
            end else if (!n_auto) begin
               m_auto = 0;
            end else if (press) begin
               m_tick = 0;
            end else if (n_enb) begin
               m_tick++;
               if (m_tick == AS) begin adv = 1; m_tick = 0; end
            end
            if (adv) m_cur = next_valid(m_cur, n_valid);
         end
      end else begin
         if (press || fall) begin
            e.ack = press;
            m_alarm = 0; m_cur = m_saved_cur; m_auto = m_saved_auto;
         end else if (n_enb) begin
            m_blink = !m_blink;
         end
      end
      e.cur = 3'(m_cur);
      q.push_back(e);
   endtask

   task automatic check_reset(string name);
      vectors++;
      if (cur_src !== 3'd0 || led !== {DW{1'b1}} || alarm_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: cur_src=%0d led=%h ack=%b, required cur_src=0 led=%h ack=0",
                  name, cur_src, led, alarm_ack, {DW{1'b1}});
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #2;
      rst = n_rst; enb = n_enb; mode_btn = n_btn; auto_en = n_auto;
      alarm_req = n_alarm; src_valid = n_valid; src_data = n_data;
      model_step();
      if (n_rst) begin
         #1 check_reset("rst_immediate");
      end
   endtask

   task automatic press_btn();
      n_btn = 1; repeat (4) cyc();
      n_btn = 0; repeat (4) cyc();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (cur_src !== e.cur || led !== e.led || alarm_ack !== e.ack) begin
               miscompares++;
               $display("FAIL scoreboard @%0t: cur_src=%0d led=%h ack=%b, required cur_src=%0d led=%h ack=%b",
                        $time, cur_src, led, alarm_ack, e.cur, e.led, e.ack);
            end
         end
      end
   end

   initial begin : driver
      n_rst = 1; n_enb = 0; n_btn = 0; n_auto = 0; n_alarm = 0;
      n_valid = '1; n_data = {$urandom, $urandom};
      rst = 1; enb = 0; mode_btn = 0; auto_en = 0; alarm_req = 0;
      src_valid = n_valid; src_data = n_data;
      reset_model();
      #1 check_reset("rst_initial");
      repeat (3) cyc();
      n_rst = 0;

      // Manual stepping over a sparse valid mask
      n_valid = 4'b1011;
      repeat (3) press_btn();

      // Auto scroll, with a press in the middle of a count
      n_valid = '1; n_auto = 1; cyc();
      for (int k = 0; k < 16; k++) begin
         n_enb = 1; n_btn = (k == 7 || k == 8); cyc();
         n_enb = 0; cyc(); cyc();
      end
      n_btn = 0; repeat (4) cyc();

      // Alarm from AUTO at source 1, blinking, acknowledged by press
      for (int t = 0; t < 8 && m_cur != 1; t++) press_btn();
      n_alarm = 1; cyc();
      repeat (4) begin n_enb = 1; cyc(); n_enb = 0; cyc(); cyc(); end
      press_btn();
      n_alarm = 0; repeat (3) cyc();

      // Alarm rise, press and enb landing on the same edge
      n_btn = 1; cyc(); cyc();
      n_alarm = 1; n_enb = 1; cyc();
      n_enb = 0; n_btn = 0; repeat (4) cyc();
      n_alarm = 0; repeat (3) cyc();

      // Single valid source, then the shown source disappears
      n_auto = 0; n_valid = 4'b0001; press_btn();
      n_valid = 4'b0100; repeat (3) cyc();

      // Reset in ALARM with alarm_req held high
      n_valid = '1; n_alarm = 1; repeat (3) cyc();
      n_rst = 1; cyc(); cyc();
      n_rst = 0; repeat (5) cyc();
      n_alarm = 0; cyc(); n_alarm = 1; repeat (3) cyc();
      n_alarm = 0; repeat (2) cyc();

      for (int c = 0; c < 3000; c++) begin
         n_enb = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) n_btn = ~n_btn;
         if ($urandom_range(0, 40) == 0) n_auto = ~n_auto;
         if ($urandom_range(0, 30) == 0) n_alarm = ~n_alarm;
         if ($urandom_range(0, 25) == 0) n_valid = NS'($urandom);
         if ($urandom_range(0, 10) == 0) n_data = {$urandom, $urandom};
         n_rst = ($urandom_range(0, 300) == 0);
         cyc();
      end
      n_rst = 0; n_enb = 0;
      repeat (3) cyc();
      repeat (3) @(posedge clk);
      #3;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/disp_mode_ctrl.md
DISP_MODE_CTRL -- requirements
Module: disp_mode_ctrl

Interface
REQ-001 The block SHALL have the parameter NUM_DIGITS, default 4, giving the number of display digits (4 bits each).
REQ-002 The block SHALL have the parameter NUM_SRC, default 4, giving the number of display sources (2..8).
REQ-003 The block SHALL have the parameter AUTO_SEC, default 5, giving the number of enb ticks per auto-scroll step (1..63).
REQ-004 The block SHALL have the parameter ALARM_SRC, default NUM_SRC-1, giving the source index shown during an alarm.
REQ-005 The block SHALL have the port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have the port rst  input  1  reset, asynchronous and active-high.
REQ-007 The block SHALL have the port enb  input  1  1 Hz single-cycle enable tick.
REQ-008 The block SHALL have the port src_data  input  NUM_SRC*NUM_DIGITS*4  packed digits; source s, digit d occupies bits [(s*NUM_DIGITS+d)*4 +: 4].
REQ-009 The block SHALL have the port src_valid  input  NUM_SRC  per-source enable; invalid sources are skipped.
REQ-010 The block SHALL have the port mode_btn  input  1  asynchronous mode button, level.
REQ-011 The block SHALL have the port auto_en  input  1  auto-scroll enable, level.
REQ-012 The block SHALL have the port alarm_req  input  1  alarm active, level, synchronous to clk.
REQ-013 The block SHALL have the port led  output  NUM_DIGITS*4  registered display digits.
REQ-014 The block SHALL have the port cur_src  output  3  registered index of the displayed source.
REQ-015 The block SHALL have the port alarm_ack  output  1  single-cycle pulse when the user acknowledges an alarm.

Function
REQ-016 mode_btn SHALL pass through a 2-flop synchroniser; a press is a rising edge of the synchronised level, giving 3 clk cycles from pin to press.
REQ-017 The FSM SHALL have three states: MANUAL, AUTO and ALARM.
REQ-018 Advance SHALL set cur_src to the next index with src_valid=1, searching upward and wrapping NUM_SRC-1 -> 0.
REQ-019 If no other source is valid, advance SHALL leave cur_src unchanged.
REQ-020 MANUAL: a press SHALL advance; auto_en=1 SHALL go to AUTO and clear the tick counter.
REQ-021 AUTO: a press SHALL advance and clear the tick counter.
REQ-022 AUTO: each enb SHALL increment a 6-bit tick counter; at count AUTO_SEC-1 with enb, the block SHALL advance and reset the counter to 0.
REQ-023 AUTO: auto_en=0 SHALL go to MANUAL with cur_src held.
REQ-024 A rising edge of alarm_req in MANUAL or AUTO SHALL save cur_src and the prior state, go to ALARM, set cur_src=ALARM_SRC, and set blink phase=on.
REQ-025 ALARM: each enb SHALL toggle blink phase; in the off phase, every led digit SHALL be 4'hF (blank code).
REQ-026 ALARM: a press SHALL pulse alarm_ack for 1 cycle and return to the saved state and source.
REQ-027 ALARM: a falling edge of alarm_req SHALL return to the saved state and source without alarm_ack.
REQ-028 Re-entering ALARM SHALL require a new rising edge of alarm_req.
REQ-029 Priority in the same cycle SHALL be: alarm_req rise > press > enb-driven advance; lower-priority events in that cycle are discarded.
REQ-030 If cur_src becomes invalid (src_valid drops) in MANUAL or AUTO, the block SHALL advance on the next cycle.
REQ-031 ALARM SHALL ignore src_valid.
REQ-032 led SHALL equal the selected source's digits, registered, so that led reflects src_data and cur_src one cycle later.
REQ-033 A press together with auto_en rising in MANUAL SHALL both advance and go to AUTO.

Reset
REQ-034 While rst is high, cur_src SHALL be 0, led all 4'hF, alarm_ack 0, state MANUAL, tick counter 0, blink phase on, saved state/source 0, and synchroniser flops 0.
REQ-035 Reset assertion mid-ALARM SHALL abandon the alarm with no alarm_ack.
REQ-036 After rst deasserts, an alarm_req already high SHALL NOT enter ALARM until it falls and rises again.

Verification
REQ-037 Reset then src_valid=4'b1011 with 3 presses -> cur_src 0->1->3->0; led tracks each source one cycle after cur_src.
REQ-038 auto_en=1, AUTO_SEC=5, all sources valid -> cur_src increments every 5th enb; a press at the 3rd tick advances and restarts the count.
REQ-039 In AUTO at cur_src=1, alarm_req rises -> cur_src=3 and led blinks between src3 data and 4'hF on each enb; a press gives one alarm_ack pulse, then AUTO with cur_src=1.
REQ-040 alarm_req rise, press and enb in the same cycle -> ALARM entered, no advance, no alarm_ack.
REQ-041 src_valid=4'b0001 and a press -> cur_src stays 0; then src_valid drops bit 0 and sets bit 2 -> cur_src=2 within 2 cycles.
REQ-042 rst pulse while in ALARM -> all outputs at reset values immediately; with alarm_req held high, no re-entry to ALARM.
